// File: rtl/fir_frame_features.sv
`default_nettype none
// ============================================================================
// Module   : fir_frame_features
// Purpose  : Reduces fixed-length frames of FIR output to energy, peak and
//            zero-crossing features behind a one-entry valid/ready slot.
//            Optional macro FEAT_OVERRUN_CNT_EN adds a dropped-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module fir_frame_features #(
  parameter int DW        = 32,
  parameter int FRAME_LEN = 256,
  parameter int AW        = 48,
  parameter int CW        = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          feat_valid,
  input  logic          feat_ready,
  output logic [AW-1:0] feat_energy,
  output logic [DW-1:0] feat_peak,
  output logic [CW-1:0] feat_zcr,
  output logic [CW-1:0] feat_frame_idx,
  output logic          overrun
`ifdef FEAT_OVERRUN_CNT_EN
  ,
  output logic [CW-1:0] overrun_cnt
`endif
);

  localparam int              c_CNTW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(FRAME_LEN - 1);

  logic [c_CNTW-1:0] r_cnt;
  logic [AW-1:0]     r_energy;
  logic [DW-1:0]     r_peak;
  logic [CW-1:0]     r_zcr;
  logic [CW-1:0]     r_frame_idx;
  logic              r_prev_sign;

  logic              r_feat_valid;
  logic [AW-1:0]     r_feat_energy;
  logic [DW-1:0]     r_feat_peak;
  logic [CW-1:0]     r_feat_zcr;
  logic [CW-1:0]     r_feat_idx;
  logic              r_overrun;

  logic              w_sign;
  logic [DW-1:0]     w_abs;
  logic [AW:0]       w_energy_sum;
  logic [AW-1:0]     w_energy_next;
  logic [DW-1:0]     w_peak_next;
  logic [CW-1:0]     w_zcr_next;
  logic              w_last;
  logic              w_pop;
  logic              w_load;
  logic              w_drop;

  // Two's-complement negation in DW bits: -2^(DW-1) maps to 2^(DW-1),
  // which is exactly representable as an unsigned DW-bit magnitude.
  assign w_sign = in_data[DW-1];
  assign w_abs  = w_sign ? (~in_data + 1'b1) : in_data;

  assign w_energy_sum  = {1'b0, r_energy} + (AW+1)'(w_abs);
  assign w_energy_next = w_energy_sum[AW] ? {AW{1'b1}} : w_energy_sum[AW-1:0];
  assign w_peak_next   = (w_abs > r_peak) ? w_abs : r_peak;
  assign w_zcr_next    = ((w_sign != r_prev_sign) && (r_zcr != {CW{1'b1}}))
                         ? r_zcr + 1'b1 : r_zcr;

  assign w_last = in_valid && (r_cnt == c_LAST);
  assign w_pop  = r_feat_valid && feat_ready;
  assign w_load = w_last && (!r_feat_valid || feat_ready);
  assign w_drop = w_last && r_feat_valid && !feat_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt         <= '0;
      r_energy      <= '0;
      r_peak        <= '0;
      r_zcr         <= '0;
      r_frame_idx   <= '0;
      r_prev_sign   <= 1'b0;
      r_feat_valid  <= 1'b0;
      r_feat_energy <= '0;
      r_feat_peak   <= '0;
      r_feat_zcr    <= '0;
      r_feat_idx    <= '0;
      r_overrun     <= 1'b0;
    end else begin
      if (in_valid) begin
        r_prev_sign <= w_sign;
        if (w_last) begin
          r_cnt       <= '0;
          r_energy    <= '0;
          r_peak      <= '0;
          r_zcr       <= '0;
          r_frame_idx <= r_frame_idx + 1'b1;
        end else begin
          r_cnt    <= r_cnt + 1'b1;
          r_energy <= w_energy_next;
          r_peak   <= w_peak_next;
          r_zcr    <= w_zcr_next;
        end
      end
      // A completing frame may reload the slot in the same cycle it is popped.
      if (w_load) begin
        r_feat_valid  <= 1'b1;
        r_feat_energy <= w_energy_next;
        r_feat_peak   <= w_peak_next;
        r_feat_zcr    <= w_zcr_next;
        r_feat_idx    <= r_frame_idx;
      end else if (w_pop) begin
        r_feat_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef FEAT_OVERRUN_CNT_EN
  logic [CW-1:0] r_overrun_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_overrun_cnt <= '0;
    end else if (w_drop && (r_overrun_cnt != {CW{1'b1}})) begin
      r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

  assign feat_valid     = r_feat_valid;
  assign feat_energy    = r_feat_energy;
  assign feat_peak      = r_feat_peak;
  assign feat_zcr       = r_feat_zcr;
  assign feat_frame_idx = r_feat_idx;
  assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_features.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_frame_features
// Purpose  : Scoreboard bench for fir_frame_features (FRAME_LEN=4, AW=33).
//            Honours FEAT_OVERRUN_CNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_frame_features;

  localparam int DW        = 32;
  localparam int FRAME_LEN = 4;
  localparam int AW        = 33;
  localparam int CW        = 16;
  localparam longint unsigned E_MAX = (64'd1 << AW) - 1;

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          feat_valid;
  logic          feat_ready;
  logic [AW-1:0] feat_energy;
  logic [DW-1:0] feat_peak;
  logic [CW-1:0] feat_zcr;
  logic [CW-1:0] feat_frame_idx;
  logic          overrun;
`ifdef FEAT_OVERRUN_CNT_EN
  logic [CW-1:0] overrun_cnt;
`endif

  fir_frame_features #(.DW(DW), .FRAME_LEN(FRAME_LEN), .AW(AW), .CW(CW)) dut (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_data(in_data),
    .feat_valid(feat_valid),
    .feat_ready(feat_ready),
    .feat_energy(feat_energy),
    .feat_peak(feat_peak),
    .feat_zcr(feat_zcr),
    .feat_frame_idx(feat_frame_idx),
    .overrun(overrun)
`ifdef FEAT_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    longint unsigned energy;
    longint unsigned peak;
    int unsigned     zcr;
    int unsigned     idx;
  } feat_t;

  feat_t       sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state: frame-level view of the stream and the slot.
  int          m_frame[$];
  bit          m_full, m_ovr, m_prev;
  int unsigned m_idx, m_ocnt;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic make_feat(output feat_t f);
    longint          e  = 0;
    longint unsigned pk = 0;
    int unsigned     z  = 0;
    foreach (m_frame[i]) begin
      longint s = longint'(m_frame[i]);
      longint a = (s < 0) ? -s : s;
      bit     sg = (s < 0);
      e += a;
      if (longint'(pk) < a) pk = longint'(a);
      if (sg != m_prev) z++;
      m_prev = sg;
    end
    f.energy = (longint'(e) > longint'(E_MAX)) ? E_MAX : longint'(e);
    f.peak   = pk;
    f.zcr    = (z > 65535) ? 65535 : z;
    f.idx    = m_idx;
  endtask

  // One clock of stimulus; checks slot/overrun state left by the previous edge.
  task automatic cyc(input bit v, input int d, input bit rdy);
    feat_t f;
    @(posedge CLK); #2;
    chk("feat_valid", feat_valid, m_full);
    chk("overrun", overrun, m_ovr);
`ifdef FEAT_OVERRUN_CNT_EN
    chk("overrun_cnt", overrun_cnt, m_ocnt);
`endif
    in_valid   = v;
    in_data    = d;
    feat_ready = rdy;
    if (v) m_frame.push_back(d);
    if (v && m_frame.size() == FRAME_LEN) begin
      make_feat(f);
      if (!m_full || rdy) begin
        sb_q.push_back(f);
        m_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
        if (m_ocnt < 65535) m_ocnt++;
      end
      m_idx = (m_idx + 1) % 65536;
      m_frame.delete();
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    RST = 1'b1; in_valid = 1'b0; in_data = '0; feat_ready = 1'b0;
    m_full = 0; m_ovr = 0; m_prev = 0; m_idx = 0; m_ocnt = 0;
    m_frame.delete();
    sb_q.delete();
    @(posedge CLK); #2;
    RST = 1'b0;
    chk("rst_valid", feat_valid, 0);
    chk("rst_energy", feat_energy, 0);
    chk("rst_peak", feat_peak, 0);
    chk("rst_zcr", feat_zcr, 0);
    chk("rst_idx", feat_frame_idx, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  // Monitor: whenever the slot is full, its contents must equal the oldest
  // expected frame; a handshake retires that entry.
  always @(negedge CLK) begin
    if (!RST && feat_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got feat_valid=1, expected empty slot");
      end else begin
        chk("sb_energy", feat_energy, sb_q[0].energy);
        chk("sb_peak", feat_peak, sb_q[0].peak);
        chk("sb_zcr", feat_zcr, sb_q[0].zcr);
        chk("sb_idx", feat_frame_idx, sb_q[0].idx);
        if (feat_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = '0; feat_ready = 1'b0;
    do_reset();

    // Basic frame
    cyc(1, 10, 0); cyc(1, -20, 0); cyc(1, 30, 0); cyc(1, -40, 0);
    cyc(0, 0, 1);
    chk("basic_valid", feat_valid, 1);
    chk("basic_energy", feat_energy, 100);
    chk("basic_peak", feat_peak, 40);
    chk("basic_zcr", feat_zcr, 3);
    chk("basic_idx", feat_frame_idx, 0);
    cyc(0, 0, 0);
    chk("basic_pop", feat_valid, 0);

    // Sign history across a frame boundary
    do_reset();
    cyc(1, 5, 1); cyc(1, 5, 1); cyc(1, 5, 1); cyc(1, -5, 1);
    cyc(1, -1, 1); cyc(1, -1, 1); cyc(1, 2, 1); cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("xfrm_zcr", feat_zcr, 1);
    chk("xfrm_idx", feat_frame_idx, 1);
    chk("xfrm_peak", feat_peak, 2);
    chk("xfrm_energy", feat_energy, 4);
    cyc(0, 0, 1);

    // Most-negative input and energy clamp
    for (int i = 0; i < 4; i++) cyc(1, int'(32'h8000_0000), 0);
    cyc(0, 0, 0);
    chk("sat_peak", feat_peak, 64'd2147483648);
    chk("sat_energy", feat_energy, 64'd8589934591);
    cyc(0, 0, 1);

    // Backpressure across three frames
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1, int'($urandom_range(0, 200)) - 100, 0);
    cyc(0, 0, 0);
    chk("ovr_hold_idx", feat_frame_idx, 0);
    chk("ovr_flag", overrun, 1);
`ifdef FEAT_OVERRUN_CNT_EN
    chk("ovr_cnt", overrun_cnt, 2);
`endif
    cyc(0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, int'($urandom_range(0, 200)) - 100, 0);
    cyc(0, 0, 0);
    chk("ovr_next_idx", feat_frame_idx, 3);
    cyc(0, 0, 1);

    // Pop and reload on the same edge
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, int'($urandom_range(0, 50)) - 25, 0);
    cyc(1, 7, 1);
    cyc(0, 0, 0);
    chk("swap_valid", feat_valid, 1);
    chk("swap_idx", feat_frame_idx, 1);
    chk("swap_overrun", overrun, 0);
    cyc(0, 0, 1);

    // Reset discards a partial frame
    do_reset();
    cyc(1, 100, 0); cyc(1, 100, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("mid_energy", feat_energy, 4);
    chk("mid_peak", feat_peak, 1);
    chk("mid_zcr", feat_zcr, 0);
    chk("mid_idx", feat_frame_idx, 0);
    chk("mid_overrun", overrun, 0);
    cyc(0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int d;
      case ($urandom % 8)
        0:       d = int'(32'h8000_0000);
        1:       d = int'(32'h7fff_ffff);
        2:       d = 0;
        3:       d = int'($urandom);
        default: d = int'($urandom_range(0, 2000)) - 1000;
      endcase
      cyc(($urandom % 4) != 0, d, ($urandom % 3) != 0);
    end
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    @(negedge CLK); #1;
    chk("sb_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_frame_features.md
Name: fir_frame_features

Overview:
- Stage directly downstream of the 8-tap FIR. Consumes the FIR's 32-bit signed filtered stream, one sample per enable strobe.
- Reduces each fixed-length frame to three classifier features: absolute-sum energy, peak magnitude and zero-crossing count.
- Presents the features through a one-entry valid/ready output slot to the classifier front end.

Parameters:
- DW, 32, input sample width (signed).
- FRAME_LEN, 256, samples per frame (>=2).
- AW, 48, energy accumulator/output width (unsigned).
- CW, 16, zero-crossing count and frame-index width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  sample strobe; the FIR stage's output is qualified one cycle after its EN.
- in_data  in  DW  signed filtered sample.
- feat_valid  out  1  feature slot full.
- feat_ready  in  1  consumer accepts slot.
- feat_energy  out  AW  sum of |x| over frame, saturating.
- feat_peak  out  DW  max |x| over frame, unsigned.
- feat_zcr  out  CW  sign changes within frame.
- feat_frame_idx  out  CW  index of completed frame, wraps modulo 2^CW.
- overrun  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (RST=1 at a clock edge): all outputs 0, accumulators 0, sample counter 0, prev_sign = non-negative, slot empty. A partial frame in progress is discarded.
- in_valid=0: no state change except a slot pop.
- Per in_valid=1 cycle, with abs = |in_data| computed at DW+1 bits:
  - abs(-2^(DW-1)) = 2^(DW-1), representable in the unsigned DW-bit peak.
  - energy_acc += abs; clamp at 2^AW-1, never wraps.
  - peak_acc = max(peak_acc, abs).
  - Zero counts as non-negative. zcr_acc += 1 when sign(in_data) != prev_sign; prev_sign is then updated.
  - prev_sign carries across frame boundaries and is cleared only by RST.
  - zcr_acc saturates at 2^CW-1.
- Sample counter runs 0..FRAME_LEN-1. On in_valid with counter == FRAME_LEN-1, the frame completes:
  - Final values include the current sample.
  - Accumulators load 0 (next frame starts empty) and the counter returns to 0.
  - frame_idx_cnt increments by 1 (wraps), including for dropped frames.
- Slot load: the completed frame's features load the output registers when the slot is empty, or is being popped the same cycle (feat_valid && feat_ready).
  - feat_valid rises the cycle after the completing in_valid cycle (latency 1).
  - feat_frame_idx = frame_idx_cnt value before the increment. The first frame reports idx 0.
- Slot pop: feat_valid && feat_ready clears feat_valid next cycle unless a reload occurs the same cycle; a reload keeps feat_valid=1 with the new data.
- Output registers hold stable while feat_valid=1 and feat_ready=0.
- Overrun: frame completes while slot is full and not popping.
  - New features are discarded; the slot keeps the old frame.
  - overrun is set and stays 1 until RST.
  - The index gap in feat_frame_idx identifies lost frames.
- in_valid may assert every cycle; no backpressure to the input. Input throughput is 1 sample/cycle always.

Optional Feature:
- Macro FEAT_OVERRUN_CNT_EN.
- Defined: adds port overrun_cnt (out, CW). It counts dropped frames, saturates at 2^CW-1, and is cleared by RST.
- Undefined: port absent, no counter logic. The sticky overrun flag exists in both builds.

Test Plan (FRAME_LEN=4, CW=16 unless noted):
- Basic frame: after RST, in_valid on 4 consecutive cycles with 10,-20,30,-40 -> feat_valid 1 cycle after the 4th sample; energy=100, peak=40, zcr=3, idx=0; feat_ready=1 -> feat_valid drops next cycle.
- Cross-frame sign: frame A 5,5,5,-5 then frame B -1,-1,2,0 -> A zcr=1; B zcr=1 (the -5 to -1 boundary is not a crossing; the -1 to 2 step is; 2 to 0 is not); B idx=1; B peak=2, energy=4.
- Saturation: DW=32, AW=33, four samples of -2147483648 -> peak=2147483648, energy=8589934591 (clamped).
- Backpressure/overrun: feat_ready held 0 across 3 complete frames -> slot holds frame idx 0 with unchanged values; overrun=1 after the 2nd frame completes; with FEAT_OVERRUN_CNT_EN, overrun_cnt=2. Release feat_ready -> idx 0 popped. The next frame reports idx 3.
- Simultaneous pop and load: feat_ready=1 on the same cycle the next frame completes -> feat_valid stays 1 continuously, data switches to the new frame, overrun stays 0.
- Reset mid-frame: 2 samples of 100, RST for 1 cycle, then 4 samples of 1 -> energy=4, peak=1, zcr=0, idx=0, overrun=0.
